// File: rtl/pipe_add_pkg.sv
// Shared constants and types for the pipelined chunk adder.
package pipe_add_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 8;

    typedef struct packed {
        logic                 carry;
        logic [DEF_CHUNK-1:0] sum;
    } chunk_res_t;

    // Number of pipeline stages for a given operand and chunk width.
    function automatic int unsigned stages_of(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipe_add_chunk.sv
// Combinational CHUNK-bit adder; also exports the carry into its MSB for overflow detection.
module pipe_add_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum_c,
    output logic             cout_c,
    output logic             msb_cin_c
);

    localparam int unsigned TW = CHUNK + 1;

    logic [CHUNK:0] total;

    assign total     = {1'b0, a} + {1'b0, b} + TW'(cin);
    assign sum_c     = total[CHUNK-1:0];
    assign cout_c    = total[CHUNK];
    // The MSB sum bit is a^b^carry_in, so the carry into it is recovered by XOR.
    assign msb_cin_c = a[CHUNK-1] ^ b[CHUNK-1] ^ sum_c[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// Elastic pipelined adder: one CHUNK-bit slice of the add per stage, valid/ready on both sides.
// Optional PIPE_ADD_SUB_EN adds a sub port selecting a - b.
module pipe_adder
    import pipe_add_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = stages_of(WIDTH, CHUNK);

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PIPE_ADD_SUB_EN
    // Subtract as a + ~b + 1; the sub request travels with the beat via the inverted operand.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Stage registers: acc holds finished sum chunks below and untouched A chunks above.
    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] acc_q   [STAGES];
    logic [WIDTH-1:0] bop_q   [STAGES];
    logic             ovf_q;

    logic             src_v      [STAGES];
    logic             src_c      [STAGES];
    logic [WIDTH-1:0] src_a      [STAGES];
    logic [WIDTH-1:0] src_b      [STAGES];
    logic [WIDTH-1:0] nxt_acc    [STAGES];
    logic [CHUNK-1:0] chunk_sum  [STAGES];
    logic             chunk_cout [STAGES];
    logic             chunk_msbc [STAGES];
    logic [STAGES:0]  ready_c;

    assign ready_c[STAGES] = out_ready;
    assign in_ready        = ready_c[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

        if (k == 0) begin : g_first
            assign src_v[k] = in_valid;
            assign src_a[k] = a;
            assign src_b[k] = b_eff;
            assign src_c[k] = cin_eff;
        end else begin : g_next
            assign src_v[k] = valid_q[k-1];
            assign src_a[k] = acc_q[k-1];
            assign src_b[k] = bop_q[k-1];
            assign src_c[k] = carry_q[k-1];
        end

        pipe_add_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a         (src_a[k][k*CHUNK +: CHUNK]),
            .b         (src_b[k][k*CHUNK +: CHUNK]),
            .cin       (src_c[k]),
            .sum_c     (chunk_sum[k]),
            .cout_c    (chunk_cout[k]),
            .msb_cin_c (chunk_msbc[k])
        );

        assign nxt_acc[k] = (src_a[k] & ~MASK) | (WIDTH'(chunk_sum[k]) << (k * CHUNK));
        assign ready_c[k] = !valid_q[k] | ready_c[k+1];
    end

    // Each stage advances whenever its slot is free or its contents move on downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                acc_q[k]   <= '0;
                bop_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready_c[k]) begin
                    valid_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        acc_q[k]   <= nxt_acc[k];
                        bop_q[k]   <= src_b[k];
                        carry_q[k] <= chunk_cout[k];
                    end
                end
            end
            if (ready_c[STAGES-1] && src_v[STAGES-1]) begin
                ovf_q <= chunk_msbc[STAGES-1] ^ chunk_cout[STAGES-1];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = acc_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule
